// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one doubleword RAM port.
// Handles alignment faults, byte-lane steering, load extension and a RAM wait timeout.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IF_REQ,
    input  logic [63:0] IF_ADDR,
    output logic [31:0] IF_RDATA,
    output logic        IF_ACK,
    output logic        IF_FAULT,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_UNSIGNED,
    input  logic [63:0] MEM_ADDR,
    input  logic [63:0] MEM_WDATA,
    output logic [63:0] MEM_RDATA,
    output logic        MEM_ACK,
    output logic        MEM_LAM,
    output logic        MEM_SAM,
    output logic        MEM_LAF,
    output logic        MEM_SAF,
    output logic        RAM_EN,
    output logic        RAM_WE,
    output logic [63:0] RAM_ADDR,
    output logic [63:0] RAM_WDATA,
    output logic [7:0]  RAM_BE,
    input  logic [63:0] RAM_RDATA,
    input  logic        RAM_READY
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    localparam logic       OWN_IF    = 1'b0;
    localparam logic       OWN_MEM   = 1'b1;
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state, state_n;
    logic        owner, owner_n;
    logic [7:0]  wait_cnt, wait_cnt_n;
    logic [2:0]  lane, lane_n;
    logic [1:0]  size, size_n;
    logic        uns, uns_n;
    logic        we, we_n;

    logic        ram_en_n, ram_we_n;
    logic [63:0] ram_addr_n, ram_wdata_n;
    logic [7:0]  ram_be_n;
    logic        if_ack_n, if_fault_n;
    logic [31:0] if_rdata_n;
    logic        mem_ack_n, lam_n, sam_n, laf_n, saf_n;
    logic [63:0] mem_rdata_n;

    logic        grant_mem, misaligned;
    logic [63:0] grant_addr, shifted, load_val;

    function automatic logic [7:0] size_mask(input logic [1:0] s);
        case (s)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // The owner register doubles as the round-robin history for ties
    always_comb begin
        grant_mem  = MEM_REQ && (!IF_REQ || owner == OWN_IF);
        grant_addr = grant_mem ? MEM_ADDR : IF_ADDR;
        if (grant_mem) begin
            case (MEM_SIZE)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = MEM_ADDR[0];
                2'b10:   misaligned = MEM_ADDR[1:0] != 2'b00;
                default: misaligned = MEM_ADDR[2:0] != 3'b000;
            endcase
        end else begin
            misaligned = IF_ADDR[1:0] != 2'b00;
        end

        shifted = RAM_RDATA >> {lane, 3'b000};
        case (size)
            2'b00:   load_val = uns ? {56'h0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns ? {48'h0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'b10:   load_val = uns ? {32'h0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        wait_cnt_n  = wait_cnt;
        lane_n      = lane;
        size_n      = size;
        uns_n       = uns;
        we_n        = we;
        ram_en_n    = RAM_EN;
        ram_we_n    = RAM_WE;
        ram_addr_n  = RAM_ADDR;
        ram_wdata_n = RAM_WDATA;
        ram_be_n    = RAM_BE;
        if_ack_n    = 1'b0;
        if_fault_n  = 1'b0;
        if_rdata_n  = '0;
        mem_ack_n   = 1'b0;
        lam_n       = 1'b0;
        sam_n       = 1'b0;
        laf_n       = 1'b0;
        saf_n       = 1'b0;
        mem_rdata_n = '0;

        case (state)
            IDLE: begin
                if (IF_REQ || MEM_REQ) begin
                    owner_n    = grant_mem;
                    wait_cnt_n = '0;
                    lane_n     = grant_addr[2:0];
                    size_n     = grant_mem ? MEM_SIZE : 2'b10;
                    uns_n      = grant_mem && MEM_UNSIGNED;
                    we_n       = grant_mem && MEM_WE;
                    if (misaligned) begin
                        state_n   = RESP;
                        mem_ack_n = grant_mem;
                        lam_n     = grant_mem && !MEM_WE;
                        sam_n     = grant_mem && MEM_WE;
                        if_ack_n  = !grant_mem;
                        if_fault_n = !grant_mem;
                    end else begin
                        state_n     = ACC;
                        ram_en_n    = 1'b1;
                        ram_we_n    = grant_mem && MEM_WE;
                        ram_addr_n  = {grant_addr[63:3], 3'b000};
                        ram_be_n    = grant_mem ? (size_mask(MEM_SIZE) << grant_addr[2:0])
                                                : (8'h0F << grant_addr[2:0]);
                        ram_wdata_n = grant_mem ? (MEM_WDATA << {grant_addr[2:0], 3'b000}) : 64'h0;
                    end
                end
            end
            ACC: begin
                if (RAM_READY || wait_cnt == LAST_WAIT) begin
                    state_n  = RESP;
                    ram_en_n = 1'b0;
                    ram_we_n = 1'b0;
                    ram_be_n = 8'h00;
                    if (owner == OWN_MEM) begin
                        mem_ack_n = 1'b1;
                        if (RAM_READY) begin
                            mem_rdata_n = we ? 64'h0 : load_val;
                        end else begin
                            laf_n = !we;
                            saf_n = we;
                        end
                    end else begin
                        if_ack_n = 1'b1;
                        if (RAM_READY) begin
                            if_rdata_n = lane[2] ? RAM_RDATA[63:32] : RAM_RDATA[31:0];
                        end else begin
                            if_fault_n = 1'b1;
                        end
                    end
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            wait_cnt  <= '0;
            lane      <= '0;
            size      <= '0;
            uns       <= 1'b0;
            we        <= 1'b0;
            RAM_EN    <= 1'b0;
            RAM_WE    <= 1'b0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            RAM_BE    <= '0;
            IF_ACK    <= 1'b0;
            IF_FAULT  <= 1'b0;
            IF_RDATA  <= '0;
            MEM_ACK   <= 1'b0;
            MEM_LAM   <= 1'b0;
            MEM_SAM   <= 1'b0;
            MEM_LAF   <= 1'b0;
            MEM_SAF   <= 1'b0;
            MEM_RDATA <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            wait_cnt  <= wait_cnt_n;
            lane      <= lane_n;
            size      <= size_n;
            uns       <= uns_n;
            we        <= we_n;
            RAM_EN    <= ram_en_n;
            RAM_WE    <= ram_we_n;
            RAM_ADDR  <= ram_addr_n;
            RAM_WDATA <= ram_wdata_n;
            RAM_BE    <= ram_be_n;
            IF_ACK    <= if_ack_n;
            IF_FAULT  <= if_fault_n;
            IF_RDATA  <= if_rdata_n;
            MEM_ACK   <= mem_ack_n;
            MEM_LAM   <= lam_n;
            MEM_SAM   <= sam_n;
            MEM_LAF   <= laf_n;
            MEM_SAF   <= saf_n;
            MEM_RDATA <= mem_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected responses,
// a forked monitor pops and compares on every ACK.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IF_REQ;
    logic [63:0] IF_ADDR;
    logic [31:0] IF_RDATA;
    logic        IF_ACK, IF_FAULT;
    logic        MEM_REQ, MEM_WE, MEM_UNSIGNED;
    logic [1:0]  MEM_SIZE;
    logic [63:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic        MEM_ACK, MEM_LAM, MEM_SAM, MEM_LAF, MEM_SAF;
    logic        RAM_EN, RAM_WE;
    logic [63:0] RAM_ADDR, RAM_WDATA, RAM_RDATA;
    logic [7:0]  RAM_BE;
    logic        RAM_READY;

    mem_port_arbiter #(.MAX_WAIT(15)) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_ACK(IF_ACK), .IF_FAULT(IF_FAULT),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_SIZE(MEM_SIZE), .MEM_UNSIGNED(MEM_UNSIGNED),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
        .MEM_LAM(MEM_LAM), .MEM_SAM(MEM_SAM), .MEM_LAF(MEM_LAF), .MEM_SAF(MEM_SAF),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_BE(RAM_BE), .RAM_RDATA(RAM_RDATA), .RAM_READY(RAM_READY)
    );

    always #5 CLK = ~CLK;

    // flags = {LAM, SAM, LAF, SAF, IF_FAULT}
    typedef struct packed {
        logic        is_mem;
        logic [63:0] mrdata;
        logic [31:0] irdata;
        logic [4:0]  flags;
    } resp_t;

    typedef struct {
        bit          if_req;
        logic [63:0] if_addr;
        bit          mem_req;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          ready_delay;
        bit          stray;
        bit          mem_first;
        int          exp_en;
        int          exp_ack;
        bit          chk_ram;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
    } vec_t;

    resp_t exp_q[$];
    int    n_vectors = 0;
    int    n_miscompares = 0;
    vec_t  v;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic resp_t memResp(input logic [63:0] d, input logic [3:0] f);
        resp_t r;
        r.is_mem = 1'b1; r.mrdata = d; r.irdata = 32'h0; r.flags = {f, 1'b0};
        return r;
    endfunction

    function automatic resp_t ifResp(input logic [31:0] d, input logic fault);
        resp_t r;
        r.is_mem = 1'b0; r.mrdata = 64'h0; r.irdata = d; r.flags = {4'b0000, fault};
        return r;
    endfunction

    function automatic vec_t memVec(input bit we, input logic [1:0] size, input bit uns,
                                    input logic [63:0] addr, input logic [63:0] wdata,
                                    input logic [63:0] rdata, input int dly, input int en, input int ack);
        vec_t x;
        x.if_req = 0; x.if_addr = 64'h0; x.mem_req = 1; x.we = we; x.size = size; x.uns = uns;
        x.addr = addr; x.wdata = wdata; x.rdata = rdata; x.ready_delay = dly; x.stray = 0;
        x.mem_first = 1; x.exp_en = en; x.exp_ack = ack; x.chk_ram = 0; x.exp_be = 8'h0; x.exp_wdata = 64'h0;
        return x;
    endfunction

    function automatic vec_t fetchVec(input logic [63:0] addr, input logic [63:0] rdata,
                                      input int dly, input int en, input int ack);
        vec_t x;
        x = memVec(1'b0, 2'b00, 1'b0, 64'h0, 64'h0, rdata, dly, en, ack);
        x.mem_req = 0; x.if_req = 1; x.if_addr = addr; x.mem_first = 0;
        return x;
    endfunction

    task automatic checkResetValues(input string name);
        checkOutput({name, "_ctrl"}, 128'({IF_ACK, IF_FAULT, MEM_ACK, MEM_LAM, MEM_SAM, MEM_LAF, MEM_SAF,
                                           RAM_EN, RAM_WE, RAM_BE}), 128'h0);
        checkOutput({name, "_rdata"}, 128'({IF_RDATA, MEM_RDATA}), 128'h0);
        checkOutput({name, "_ram"}, {RAM_ADDR, RAM_WDATA}, 128'h0);
    endtask

    // Issue one vector (called on a falling edge), drive RAM_READY, drop requests on ACK
    task automatic applyStimulus(input string name, input vec_t x, input resp_t r_mem, input resp_t r_if);
        int cyc = 0, first_ack = 0, en_cnt = 0, acc = 0;
        if (x.mem_req && x.if_req) begin
            if (x.mem_first) begin exp_q.push_back(r_mem); exp_q.push_back(r_if); end
            else begin exp_q.push_back(r_if); exp_q.push_back(r_mem); end
        end else if (x.mem_req) exp_q.push_back(r_mem);
        else exp_q.push_back(r_if);
        IF_ADDR = x.if_addr; MEM_WE = x.we; MEM_SIZE = x.size; MEM_UNSIGNED = x.uns;
        MEM_ADDR = x.addr; MEM_WDATA = x.wdata; RAM_RDATA = x.rdata;
        IF_REQ = x.if_req; MEM_REQ = x.mem_req;
        while ((IF_REQ || MEM_REQ) && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (RAM_EN) begin
                en_cnt++;
                if (en_cnt == 1 && x.chk_ram) begin
                    checkOutput({name, "_be"}, 128'(RAM_BE), 128'(x.exp_be));
                    checkOutput({name, "_wdata"}, 128'(RAM_WDATA), 128'(x.exp_wdata));
                    checkOutput({name, "_we"}, 128'(RAM_WE), 128'(x.we && x.mem_req));
                    checkOutput({name, "_addr"}, 128'(RAM_ADDR),
                                128'({(x.mem_req ? x.addr[63:3] : x.if_addr[63:3]), 3'b000}));
                end
                RAM_READY = (acc == x.ready_delay);
                acc++;
            end else begin
                RAM_READY = 1'b0;
                acc = 0;
            end
            if ((IF_ACK || MEM_ACK) && first_ack == 0) first_ack = cyc;
            if (IF_ACK) IF_REQ = 1'b0;
            if (MEM_ACK) MEM_REQ = 1'b0;
            if ((IF_ACK || MEM_ACK) && x.stray) RAM_READY = 1'b1;
        end
        checkOutput({name, "_done"}, 128'({IF_REQ, MEM_REQ}), 128'h0);
        checkOutput({name, "_en_cycles"}, 128'(en_cnt), 128'(x.exp_en));
        checkOutput({name, "_ack_cycle"}, 128'(first_ack), 128'(x.exp_ack));
        IF_REQ = 1'b0; MEM_REQ = 1'b0;
        @(negedge CLK);
        RAM_READY = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1; IF_REQ = 0; IF_ADDR = 0; MEM_REQ = 0; MEM_WE = 0; MEM_SIZE = 0;
        MEM_UNSIGNED = 0; MEM_ADDR = 0; MEM_WDATA = 0; RAM_RDATA = 0; RAM_READY = 0;

        fork
            begin : monitor
                bit    prev_ack;
                resp_t r;
                prev_ack = 1'b0;
                forever begin
                    @(negedge CLK);
                    if (IF_ACK || MEM_ACK) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("unexpected_ack", 128'({IF_ACK, MEM_ACK}), 128'h0);
                        end else begin
                            r = exp_q.pop_front();
                            checkOutput("ack_owner", 128'({IF_ACK, MEM_ACK}), r.is_mem ? 128'h1 : 128'h2);
                            if (r.is_mem) begin
                                checkOutput("mem_rdata", 128'(MEM_RDATA), 128'(r.mrdata));
                                checkOutput("mem_flags", 128'({MEM_LAM, MEM_SAM, MEM_LAF, MEM_SAF}),
                                            128'(r.flags[4:1]));
                            end else begin
                                checkOutput("if_rdata", 128'(IF_RDATA), 128'(r.irdata));
                                checkOutput("if_fault", 128'(IF_FAULT), 128'(r.flags[0]));
                            end
                        end
                        prev_ack = 1'b1;
                    end else begin
                        if (prev_ack)
                            checkOutput("post_ack_zero", 128'({MEM_RDATA, IF_RDATA, MEM_LAM, MEM_SAM,
                                                               MEM_LAF, MEM_SAF, IF_FAULT}), 128'h0);
                        prev_ack = 1'b0;
                    end
                end
            end
        join_none

        repeat (2) @(negedge CLK);
        checkResetValues("reset_state");
        RESET = 1'b0;
        @(negedge CLK);

        v = memVec(0, 2'b11, 0, 64'h0, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 2, 2);
        v.if_req = 1; v.if_addr = 64'h104;
        applyStimulus("tie_mem_first", v, memResp(64'hAAAA_BBBB_CCCC_DDDD, 4'b0000), ifResp(32'hAAAA_BBBB, 1'b0));

        v = memVec(0, 2'b01, 0, 64'h1006, 64'h0, 64'h8123_0000_0000_0000, 0, 1, 2);
        v.chk_ram = 1; v.exp_be = 8'hC0; v.exp_wdata = 64'h0;
        applyStimulus("load_half_s", v, memResp(64'hFFFF_FFFF_FFFF_8123, 4'b0000), ifResp(32'h0, 1'b0));

        v = fetchVec(64'h104, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1, 2);
        v.chk_ram = 1; v.exp_be = 8'hF0; v.exp_wdata = 64'h0;
        applyStimulus("fetch_hi", v, memResp(64'h0, 4'b0000), ifResp(32'hAAAA_BBBB, 1'b0));

        v = memVec(1, 2'b10, 0, 64'h2003, 64'h1234, 64'h0, 0, 0, 1);
        applyStimulus("store_sam", v, memResp(64'h0, 4'b0100), ifResp(32'h0, 1'b0));

        v = memVec(0, 2'b10, 0, 64'h0, 64'h0, 64'hDEAD, -1, 15, 16);
        v.stray = 1;
        applyStimulus("load_timeout", v, memResp(64'h0, 4'b0010), ifResp(32'h0, 1'b0));

        v = memVec(1, 2'b00, 0, 64'h2005, 64'h5A, 64'h0, 2, 3, 4);
        v.chk_ram = 1; v.exp_be = 8'h20; v.exp_wdata = 64'h0000_5A00_0000_0000;
        applyStimulus("store_byte", v, memResp(64'h0, 4'b0000), ifResp(32'h0, 1'b0));

        v = memVec(0, 2'b00, 1, 64'h3, 64'h0, 64'h0000_0000_F000_0000, 0, 1, 2);
        v.chk_ram = 1; v.exp_be = 8'h08; v.exp_wdata = 64'h0;
        applyStimulus("load_byte_u", v, memResp(64'h0000_0000_0000_00F0, 4'b0000), ifResp(32'h0, 1'b0));

        v = memVec(0, 2'b00, 0, 64'h3, 64'h0, 64'h0000_0000_F000_0000, 0, 1, 2);
        applyStimulus("load_byte_s", v, memResp(64'hFFFF_FFFF_FFFF_FFF0, 4'b0000), ifResp(32'h0, 1'b0));

        v = memVec(0, 2'b10, 0, 64'h4, 64'h0, 64'h8000_0001_0000_0000, 1, 2, 3);
        v.chk_ram = 1; v.exp_be = 8'hF0; v.exp_wdata = 64'h0;
        applyStimulus("load_word_s", v, memResp(64'hFFFF_FFFF_8000_0001, 4'b0000), ifResp(32'h0, 1'b0));

        v = memVec(0, 2'b10, 1, 64'h4, 64'h0, 64'h8000_0001_0000_0000, 0, 1, 2);
        applyStimulus("load_word_u", v, memResp(64'h0000_0000_8000_0001, 4'b0000), ifResp(32'h0, 1'b0));

        v = memVec(0, 2'b11, 1, 64'h8, 64'h0, 64'h8000_0000_0000_0001, 0, 1, 2);
        v.chk_ram = 1; v.exp_be = 8'hFF; v.exp_wdata = 64'h0;
        applyStimulus("load_dbl", v, memResp(64'h8000_0000_0000_0001, 4'b0000), ifResp(32'h0, 1'b0));

        v = memVec(0, 2'b00, 1, 64'h7, 64'h0, 64'h1111_2222_3333_4444, 0, 2, 2);
        v.if_req = 1; v.if_addr = 64'h0; v.mem_first = 0;
        applyStimulus("tie_if_first", v, memResp(64'h11, 4'b0000), ifResp(32'h3333_4444, 1'b0));

        v = fetchVec(64'h102, 64'h0, 0, 0, 1);
        applyStimulus("fetch_misalign", v, memResp(64'h0, 4'b0000), ifResp(32'h0, 1'b1));

        v = fetchVec(64'h100, 64'h0, -1, 15, 16);
        applyStimulus("fetch_timeout", v, memResp(64'h0, 4'b0000), ifResp(32'h0, 1'b1));

        v = memVec(1, 2'b11, 0, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0, -1, 15, 16);
        v.chk_ram = 1; v.exp_be = 8'hFF; v.exp_wdata = 64'h0123_4567_89AB_CDEF;
        applyStimulus("store_timeout", v, memResp(64'h0, 4'b0001), ifResp(32'h0, 1'b0));

        v = memVec(0, 2'b01, 0, 64'h1, 64'h0, 64'h0, 0, 0, 1);
        applyStimulus("load_lam", v, memResp(64'h0, 4'b1000), ifResp(32'h0, 1'b0));

        v = memVec(1, 2'b01, 0, 64'h6, 64'h1234_5678_9ABC_DEF0, 64'h0, 1, 2, 3);
        v.chk_ram = 1; v.exp_be = 8'hC0; v.exp_wdata = 64'hDEF0_0000_0000_0000;
        applyStimulus("store_half", v, memResp(64'h0, 4'b0000), ifResp(32'h0, 1'b0));

        // Reset lands on the same edge as RAM_READY: the access must vanish without an ACK
        MEM_WE = 0; MEM_SIZE = 2'b10; MEM_UNSIGNED = 0; MEM_ADDR = 64'h10;
        RAM_RDATA = 64'h5555_6666_7777_8888; MEM_REQ = 1;
        @(negedge CLK);
        checkOutput("abort_ram_en", 128'(RAM_EN), 128'h1);
        RAM_READY = 1; RESET = 1;
        @(negedge CLK);
        checkResetValues("abort_reset");
        RESET = 0; MEM_REQ = 0; RAM_READY = 0;
        repeat (3) @(negedge CLK);

        v = memVec(1, 2'b10, 0, 64'h8, 64'hCAFE_F00D, 64'h1111_2222_3333_4444, 0, 2, 2);
        v.if_req = 1; v.if_addr = 64'h4;
        applyStimulus("tie_after_reset", v, memResp(64'h0, 4'b0000), ifResp(32'h1111_2222, 1'b0));

        repeat (3) @(negedge CLK);
        checkOutput("queue_drained", 128'(exp_q.size()), 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
